uart_port_tx: RTL and testbench



---
 rtl/uart_port_tx.sv | 201 ++++++++++++++++++++
 tb/tb_uart_port_tx.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_port_tx.sv
// uart_port_tx: 8N1 UART return path for 16-bit output-port words, queued in a small FIFO.
// Pop to start bit in 1 cycle; words stream with no gaps; writes while FULL are dropped and set OVERFLOW.
// Build option UART_TX_HEX_EN: send each word as 4 ASCII hex digits + CR LF instead of 2 raw bytes.

module uart_port_tx_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // The extra pointer bit tells a full ring from an empty one.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_dat = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push && !full) mem[wr_ptr[AW-1:0]] <= push_dat;
  end
endmodule

module uart_port_tx #(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] DATA_IN,
  input  logic        WRITE_EN,
  output logic        FULL,
  output logic        BUSY,
  output logic        OVERFLOW,
  output logic        UART_RXD_OUT
);
  localparam int DIV = CLK_FREQ / BAUD;
  localparam int CW  = $clog2(DIV);

`ifdef UART_TX_HEX_EN
  localparam logic [2:0] LAST_BYTE = 3'd5;
`else
  localparam logic [2:0] LAST_BYTE = 3'd1;
`endif

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [2:0]    byte_idx;
  logic [15:0]   word_q;
  logic [15:0]   fifo_dat;
  logic          fifo_full;
  logic          fifo_empty;
  logic          pop;
  logic          next_byte;
  logic          bit_done;
  logic [7:0]    cur_byte;
  logic          tx;

  uart_port_tx_fifo #(
    .WIDTH (16),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (CLK),
    .rst      (RST),
    .push     (WRITE_EN),
    .push_dat (DATA_IN),
    .pop      (pop),
    .pop_dat  (fifo_dat),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign FULL     = fifo_full;
  assign bit_done = (baud_cnt == CW'(DIV-1));

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    next_byte = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = START;
        end
      end
      START: begin
        if (bit_done) state_nxt = DATA;
      end
      DATA: begin
        if (bit_done && bit_idx == 3'd7) state_nxt = STOP;
      end
      STOP: begin
        if (bit_done) begin
          if (byte_idx != LAST_BYTE) begin
            next_byte = 1'b1;
            state_nxt = START;
          end else if (!fifo_empty) begin
            pop       = 1'b1;
            state_nxt = START;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      baud_cnt <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      word_q   <= '0;
      OVERFLOW <= 1'b0;
      BUSY     <= 1'b0;
    end else begin
      // Restarting the count at every bit boundary keeps each bit exactly DIV cycles.
      if (state == IDLE || bit_done) baud_cnt <= '0;
      else                           baud_cnt <= baud_cnt + CW'(1);

      if (state == START)                bit_idx <= '0;
      else if (state == DATA && bit_done) bit_idx <= bit_idx + 3'd1;

      if (pop) begin
        word_q   <= fifo_dat;
        byte_idx <= '0;
      end else if (next_byte) begin
        byte_idx <= byte_idx + 3'd1;
      end

      if (WRITE_EN && fifo_full) OVERFLOW <= 1'b1;

      // A write into an idle, empty block shows up here one edge later, when the pop happens.
      BUSY <= (state_nxt != IDLE) || !fifo_empty;
    end
  end

`ifdef UART_TX_HEX_EN
  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  always_comb begin
    case (byte_idx)
      3'd0:    cur_byte = hex_ascii(word_q[15:12]);
      3'd1:    cur_byte = hex_ascii(word_q[11:8]);
      3'd2:    cur_byte = hex_ascii(word_q[7:4]);
      3'd3:    cur_byte = hex_ascii(word_q[3:0]);
      3'd4:    cur_byte = 8'h0D;
      default: cur_byte = 8'h0A;
    endcase
  end
`else
  always_comb begin
    cur_byte = (byte_idx == 3'd0) ? word_q[15:8] : word_q[7:0];
  end
`endif

  always_comb begin
    tx = 1'b1;
    case (state)
      START:   tx = 1'b0;
      DATA:    tx = cur_byte[bit_idx];
      default: tx = 1'b1;
    endcase
  end

  assign UART_RXD_OUT = tx;
endmodule

// File: tb/tb_uart_port_tx.sv
// Bench for uart_port_tx: directed and random words checked by a line decoder against a byte/frame model.
// Define UART_TX_HEX_EN for both DUT and bench to exercise the ASCII-hex framing.
`timescale 1ns/1ps
module tb_uart_port_tx;
  localparam int DIV   = 16;
  localparam int DEPTH = 4;
  localparam int DIV2  = 100000000 / 115200;
`ifdef UART_TX_HEX_EN
  localparam int BPW = 6;
`else
  localparam int BPW = 2;
`endif

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [15:0] DATA_IN = 16'h0;
  logic        WRITE_EN = 1'b1;
  logic        FULL, BUSY, OVERFLOW, line;
  logic [15:0] data2 = 16'h0;
  logic        wr2 = 1'b0;
  logic        full2, busy2, ovf2, line2;

  int cyc   = 0;
  int total = 0;
  int bad   = 0;

  logic [7:0] rx_byte[$];
  int         rx_t[$];
  logic       rx_stop[$];
  logic [7:0] exp_q[$];

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  uart_port_tx #(.CLK_FREQ(16), .BAUD(1), .FIFO_DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST), .DATA_IN(DATA_IN), .WRITE_EN(WRITE_EN),
    .FULL(FULL), .BUSY(BUSY), .OVERFLOW(OVERFLOW), .UART_RXD_OUT(line)
  );

  uart_port_tx #(.CLK_FREQ(100000000), .BAUD(115200), .FIFO_DEPTH(DEPTH)) dut2 (
    .CLK(CLK), .RST(RST), .DATA_IN(data2), .WRITE_EN(wr2),
    .FULL(full2), .BUSY(busy2), .OVERFLOW(ovf2), .UART_RXD_OUT(line2)
  );

  // Line decoder: start edge time, mid-bit samples, stop bit value.
  initial begin : monitor
    logic [7:0] b;
    int t0;
    forever begin
      @(negedge CLK);
      if (!RST && line === 1'b0) begin
        t0 = cyc;
        repeat (DIV/2) @(negedge CLK);
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(negedge CLK);
          b[i] = line;
        end
        repeat (DIV) @(negedge CLK);
        rx_stop.push_back(line);
        rx_byte.push_back(b);
        rx_t.push_back(t0);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_word(input logic [15:0] w);
`ifdef UART_TX_HEX_EN
    for (int i = 3; i >= 0; i--) begin
      int n;
      n = int'((w >> (4*i)) & 16'hF);
      exp_q.push_back((n < 10) ? 8'(48 + n) : 8'(55 + n));
    end
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
`else
    exp_q.push_back(w[15:8]);
    exp_q.push_back(w[7:0]);
`endif
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge CLK);
  endtask

  task automatic write_word(input logic [15:0] w, output int k);
    @(negedge CLK);
    DATA_IN  = w;
    WRITE_EN = 1'b1;
    @(negedge CLK);
    WRITE_EN = 1'b0;
    k = cyc;
  endtask

  task automatic wait_bytes(input int n, input int budget, input string tag);
    int c;
    c = 0;
    while (rx_byte.size() < n && c < budget) begin
      @(negedge CLK);
      c++;
    end
    check({tag, " arrival"}, 32'(rx_byte.size() >= n), 32'd1);
  endtask

  task automatic compare_bytes(input string tag, input int t_first, input bit timed);
    check({tag, " count"}, 32'(rx_byte.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < rx_byte.size(); i++) begin
      check($sformatf("%s byte%0d", tag, i), 32'(rx_byte[i]), 32'(exp_q[i]));
      check($sformatf("%s stop%0d", tag, i), 32'(rx_stop[i]), 32'd1);
      if (timed) check($sformatf("%s start%0d", tag, i), 32'(rx_t[i]), 32'(t_first + i*10*DIV));
    end
    exp_q.delete();
    rx_byte.delete();
    rx_t.delete();
    rx_stop.delete();
  endtask

  // Line and BUSY around the end of the last stop bit of a run of nbytes starting at k+1.
  task automatic end_check(input string tag, input int k, input int nbytes);
    wait_cyc(k + nbytes*10*DIV);
    check({tag, " busy before end"}, 32'(BUSY), 32'd1);
    check({tag, " stop level"}, 32'(line), 32'd1);
    @(negedge CLK);
    check({tag, " busy after end"}, 32'(BUSY), 32'd0);
    check({tag, " idle level"}, 32'(line), 32'd1);
  endtask

  initial begin : main
    int k, k2, gap, c, mism, nbits;
    logic [15:0] w;
    logic bits[$];

    // Reset held two edges with WRITE_EN toggling.
    @(negedge CLK); WRITE_EN = 1'b0;
    @(negedge CLK); RST = 1'b0; WRITE_EN = 1'b0;
    check("reset line", 32'(line), 32'd1);
    check("reset full", 32'(FULL), 32'd0);
    check("reset busy", 32'(BUSY), 32'd0);
    check("reset overflow", 32'(OVERFLOW), 32'd0);
    repeat (4*DIV) @(negedge CLK);
    check("reset no frame", 32'(rx_byte.size()), 32'd0);
    check("reset still idle", 32'(BUSY), 32'd0);

    // Single words: start one edge after the write, exact byte spacing, BUSY drop.
    write_word(16'hA53C, k);
    model_word(16'hA53C);
    check("A53C busy low on write edge", 32'(BUSY), 32'd0);
    @(negedge CLK);
    check("A53C busy rise", 32'(BUSY), 32'd1);
    check("A53C line low", 32'(line), 32'd0);
    end_check("A53C", k, BPW);
    wait_bytes(BPW, 200, "A53C");
    compare_bytes("A53C", k + 1, 1'b1);

    write_word(16'h00F1, k);
    model_word(16'h00F1);
    end_check("00F1", k, BPW);
    wait_bytes(BPW, 200, "00F1");
    compare_bytes("00F1", k + 1, 1'b1);

    // Six writes on consecutive edges into a depth-4 FIFO.
    for (int i = 1; i <= 6; i++) begin
      @(negedge CLK);
      if (i == 2) k = cyc;
      if (i == 5) check("ovf full after 4", 32'(FULL), 32'd0);
      if (i == 6) begin
        check("ovf full after 5", 32'(FULL), 32'd1);
        check("ovf flag after 5", 32'(OVERFLOW), 32'd0);
      end
      DATA_IN  = 16'(i);
      WRITE_EN = 1'b1;
      if (i <= 5) model_word(16'(i));
    end
    @(negedge CLK);
    WRITE_EN = 1'b0;
    check("ovf flag after 6", 32'(OVERFLOW), 32'd1);
    check("ovf full after 6", 32'(FULL), 32'd1);
    end_check("ovf", k, 5*BPW);
    wait_bytes(5*BPW, 200, "ovf");
    compare_bytes("ovf", k + 1, 1'b1);
    check("ovf sticky", 32'(OVERFLOW), 32'd1);

    // Reset 100 cycles into a frame with a second word queued.
    write_word(16'h1234, k);
    write_word(16'h9999, k2);
    wait_cyc(k + 100);
    RST = 1'b1;
    @(negedge CLK);
    check("midrst line", 32'(line), 32'd1);
    check("midrst busy", 32'(BUSY), 32'd0);
    check("midrst full", 32'(FULL), 32'd0);
    check("midrst overflow", 32'(OVERFLOW), 32'd0);
    RST = 1'b0;
    repeat (250) @(negedge CLK);
    rx_byte.delete(); rx_t.delete(); rx_stop.delete();
    repeat (25*DIV) @(negedge CLK);
    check("midrst discarded", 32'(rx_byte.size()), 32'd0);
    check("midrst idle busy", 32'(BUSY), 32'd0);
    write_word(16'h5678, k);
    model_word(16'h5678);
    end_check("5678", k, BPW);
    wait_bytes(BPW, 200, "5678");
    compare_bytes("5678", k + 1, 1'b1);

    // Random words with random spacing, written only while FIFO has room.
    for (int i = 0; i < 8; i++) begin
      w   = 16'($urandom);
      gap = int'($urandom_range(0, 40));
      repeat (gap) @(negedge CLK);
      c = 0;
      while (FULL && c < 5000) begin
        @(negedge CLK);
        c++;
      end
      DATA_IN  = w;
      WRITE_EN = 1'b1;
      model_word(w);
      @(negedge CLK);
      WRITE_EN = 1'b0;
    end
    wait_bytes(8*BPW, 8*BPW*10*DIV + 500, "rand");
    repeat (2*DIV) @(negedge CLK);
    compare_bytes("rand", 0, 1'b0);
    check("rand no overflow", 32'(OVERFLOW), 32'd0);

    // Real divider: cycle-exact waveform of one word at 868 cycles per bit.
    model_word(16'h5555);
    foreach (exp_q[i]) begin
      bits.push_back(1'b0);
      for (int j = 0; j < 8; j++) bits.push_back(exp_q[i][j]);
      bits.push_back(1'b1);
    end
    exp_q.delete();
    nbits = bits.size();
    @(negedge CLK);
    data2 = 16'h5555;
    wr2   = 1'b1;
    @(negedge CLK);
    wr2 = 1'b0;
    k   = cyc;
    check("div line before start", 32'(line2), 32'd1);
    mism = 0;
    for (int off = 0; off < nbits*DIV2; off++) begin
      wait_cyc(k + 1 + off);
      if (line2 !== bits[off/DIV2]) mism++;
    end
    check("div waveform mismatches", 32'(mism), 32'd0);
    check("div busy at last cycle", 32'(busy2), 32'd1);
    @(negedge CLK);
    check("div busy after word", 32'(busy2), 32'd0);
    check("div idle level", 32'(line2), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
